wb_regfile_stage: RTL and testbench
===================================

// Module: wb_regfile_stage
// PURPOSE
//  Writeback stage of the 5-stage 64-bit pipeline; consumes the M/WB stage-register outputs.
//  Selects the writeback value (load data, ALU result or MOVI immediate), writes the 8-entry register file,
//  and serves two decode-stage read ports with same-cycle write-to-read bypass.
//  Also keeps a retired-instruction counter, a sticky decode-error flag and a registered debug read port.
// PARAMETERS
//  DATA_W   64  register/data width
//  ADDR_W   3   register index width (NREGS = 2**ADDR_W = 8)
//  CNT_W    32  retired-instruction counter width
// PORTS
//  clk            in   1        single clock, all state on posedge
//  rst            in   1        asynchronous, active-high reset
//  NOOP_WB        in   1        WB-stage instruction is NOOP
//  ADDI_WB        in   1        WB-stage instruction is ADDI
//  MOVI_WB        in   1        WB-stage instruction is MOVI
//  LW_WB          in   1        WB-stage instruction is LW
//  SW_WB          in   1        WB-stage instruction is SW (never writes the register file)
//  WRE_WB         in   1        register-write enable from decode
//  D_out_WB       in   DATA_W   data-memory read data (LW source)
//  ALU_result_WB  in   DATA_W   ALU result (ADDI source)
//  Offset_WB      in   DATA_W   sign-extended immediate (MOVI source)
//  rt_WB          in   ADDR_W   destination register index
//  rd_addr_a      in   ADDR_W   decode read port A index
//  rd_addr_b      in   ADDR_W   decode read port B index
//  rd_data_a      out  DATA_W   port A data (combinational)
//  rd_data_b      out  DATA_W   port B data (combinational)
//  dbg_addr       in   ADDR_W   debug read index
//  dbg_data       out  DATA_W   debug read data, registered
//  retire_cnt     out  CNT_W    count of retired non-NOOP instructions
//  onehot_err     out  1        sticky: >1 of {LW,ADDI,MOVI,SW} asserted in one cycle
// BEHAVIOUR
//  - Reset (async, active-high): all 8 registers, dbg_data, retire_cnt, onehot_err <= 0 immediately.
//    Reset mid-stream discards the in-flight writeback; first post-reset edge behaves normally.
//  - Write select, priority LW > ADDI > MOVI: wdata = LW ? D_out_WB : ADDI ? ALU_result_WB : Offset_WB.
//  - we = WRE_WB & ~NOOP_WB & ~SW_WB & (LW_WB|ADDI_WB|MOVI_WB) & (rt_WB != 0).
//  - Register r0 is hardwired zero: writes to r0 dropped, reads of r0 return 0 (incl. bypass path).
//  - Write occurs on posedge clk when we=1; latency 1 cycle to storage.
//  - Read ports: rd_data_x = (we && rd_addr_x==rt_WB) ? wdata : regs[rd_addr_x]  (write-first bypass,
//    same cycle, so decode never needs a WB->ID forwarding stall). Both ports may bypass at once.
//  - dbg_data <= regs[dbg_addr] each posedge (1-cycle latency, pre-write value, no bypass).
//  - retire_cnt += 1 on posedge when ~NOOP_WB & (LW|ADDI|MOVI|SW); SW counts though it doesn't write.
//    Wraps 2**CNT_W-1 -> 0 silently; no saturation.
//  - onehot_err set on posedge when popcount{LW_WB,ADDI_WB,MOVI_WB,SW_WB} > 1; cleared only by rst.
//    The write still happens per priority rule (SW in the set still blocks the write).
//  - NOOP_WB=1 overrides all: no write, no count, no error check.
//  - WRE_WB=0 with LW/ADDI/MOVI: no write, instruction still counts as retired.
// STRUCTURE
//  - Shared package pipe_pkg: DATA_W, ADDR_W, NREGS constants; WB-source select enum
//    {WB_SRC_MEM, WB_SRC_ALU, WB_SRC_IMM}; used also by the ID stage and hazard unit.
//  - One sub-module: wb_regfile (NREGS x DATA_W storage, 1 write + 3 read, r0 hardwired zero,
//    async reset). Select/bypass/counter/error logic stays in this top.
// TESTING
//  1. Reset: preload regs, assert rst asynchronously mid-cycle -> all regs, dbg_data, retire_cnt, onehot_err 0 at once.
//  2. ADDI rt=3 ALU=0x1234, WRE=1 -> rd_addr_a=3 reads 0x1234 same cycle (bypass), dbg_addr=3 reads 0x1234 next cycle.
//  3. LW rt=5 D_out=0xDEAD_BEEF, MOVI rt=6 Offset=0xFFFF_FFFF_FFFF_FFF0 back-to-back -> r5/r6 hold values, retire_cnt=2.
//  4. ADDI rt=0 ALU=0x55 -> r0 and rd_data for addr 0 stay 0; retire_cnt increments.
//  5. SW=1 with WRE=1 rt=2 -> r2 unchanged, retire_cnt+1; LW+ADDI together -> D_out written, onehot_err=1 sticky.
//  6. Force retire_cnt to 2**CNT_W-1 (CNT_W=4 build), retire one instr -> 0; NOOP cycles -> no change.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath sizes, the writeback-source select
// encoding, and small helpers for decoding the WB-stage instruction flags.
// The ID stage and hazard unit import this same package.
package pipe_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 3;
   localparam int NREGS  = 2 ** ADDR_W;

   // Source of the value written back into the register file
   typedef enum logic [1:0] {
      WB_SRC_MEM,
      WB_SRC_ALU,
      WB_SRC_IMM
   } wb_src_e;

   // Priority LW > ADDI > MOVI; anything else falls through to the immediate
   function automatic wb_src_e wb_src_sel(input logic lw, input logic addi);
      if (lw) begin
         return WB_SRC_MEM;
      end else if (addi) begin
         return WB_SRC_ALU;
      end
      return WB_SRC_IMM;
   endfunction

   // True when more than one of the four instruction-class flags is set
   function automatic logic multi_hot4(input logic [3:0] flags);
      return ($countones(flags) > 1);
   endfunction

endpackage

// File: rtl/wb_regfile.sv
// Register file storage: NREGS x DATA_W, one write port, three combinational
// read ports (two for decode, one for debug). Register r0 reads as zero and
// ignores writes, so no caller has to special-case it.
module wb_regfile #(
   parameter int DATA_W = pipe_pkg::DATA_W,
   parameter int ADDR_W = pipe_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   input  logic [ADDR_W-1:0] raddr_c,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic [DATA_W-1:0] rdata_c
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];

   // Storage update: clear everything on reset, otherwise write any nonzero index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Read ports, with r0 forced to zero regardless of what the array holds
   always_comb begin
      rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
      rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
      rdata_c = (raddr_c == '0) ? '0 : regs[raddr_c];
   end

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: picks the writeback value from the M/WB register outputs,
// writes the register file, bypasses the in-flight write to both decode read
// ports, and keeps a retired-instruction counter, a sticky multi-hot decode
// error flag and a registered debug read port.
module wb_regfile_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = pipe_pkg::DATA_W,
   parameter int ADDR_W = pipe_pkg::ADDR_W,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              NOOP_WB,
   input  logic              ADDI_WB,
   input  logic              MOVI_WB,
   input  logic              LW_WB,
   input  logic              SW_WB,
   input  logic              WRE_WB,
   input  logic [DATA_W-1:0] D_out_WB,
   input  logic [DATA_W-1:0] ALU_result_WB,
   input  logic [DATA_W-1:0] Offset_WB,
   input  logic [ADDR_W-1:0] rt_WB,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  retire_cnt,
   output logic              onehot_err
);

   wb_src_e           wb_src;
   logic [DATA_W-1:0] wdata;
   logic              we;
   logic              retire;
   logic              multi_hot;
   logic [DATA_W-1:0] rf_a;
   logic [DATA_W-1:0] rf_b;
   logic [DATA_W-1:0] rf_dbg;

   // Decode the WB instruction: value select, write enable, retire and error strobes
   always_comb begin
      wb_src    = wb_src_sel(LW_WB, ADDI_WB);
      wdata     = Offset_WB;
      case (wb_src)
         WB_SRC_MEM: wdata = D_out_WB;
         WB_SRC_ALU: wdata = ALU_result_WB;
         default:    wdata = Offset_WB;
      endcase
      we        = WRE_WB & ~NOOP_WB & ~SW_WB & (LW_WB | ADDI_WB | MOVI_WB)
                  & (rt_WB != '0);
      retire    = ~NOOP_WB & (LW_WB | ADDI_WB | MOVI_WB | SW_WB);
      multi_hot = ~NOOP_WB & multi_hot4({LW_WB, ADDI_WB, MOVI_WB, SW_WB});
   end

   wb_regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .waddr   (rt_WB),
      .wdata   (wdata),
      .raddr_a (rd_addr_a),
      .raddr_b (rd_addr_b),
      .raddr_c (dbg_addr),
      .rdata_a (rf_a),
      .rdata_b (rf_b),
      .rdata_c (rf_dbg)
   );

   // Write-first bypass so decode sees this cycle's writeback; we already excludes r0
   always_comb begin
      rd_data_a = (we && (rd_addr_a == rt_WB)) ? wdata : rf_a;
      rd_data_b = (we && (rd_addr_b == rt_WB)) ? wdata : rf_b;
   end

   // Debug port samples storage before this edge's write lands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_data <= '0;
      end else begin
         dbg_data <= rf_dbg;
      end
   end

   // Retired-instruction counter, wraps silently at full scale
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_cnt <= '0;
      end else if (retire) begin
         retire_cnt <= retire_cnt + CNT_W'(1);
      end
   end

   // Sticky flag for an instruction decoded into more than one class
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         onehot_err <= 1'b0;
      end else if (multi_hot) begin
         onehot_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for the writeback stage. A full-width instance carries most
// checks; a second instance with a 4-bit counter shares the same inputs so the
// counter wrap can be reached in a handful of cycles.
module tb_wb_regfile_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        NOOP_WB, ADDI_WB, MOVI_WB, LW_WB, SW_WB, WRE_WB;
   logic [63:0] D_out_WB, ALU_result_WB, Offset_WB;
   logic [2:0]  rt_WB, rd_addr_a, rd_addr_b, dbg_addr;
   logic [63:0] rd_data_a, rd_data_b, dbg_data;
   logic [31:0] retire_cnt;
   logic        onehot_err;
   logic [63:0] rd_data_a4, rd_data_b4, dbg_data4;
   logic [3:0]  retire_cnt4;
   logic        onehot_err4;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   wb_regfile_stage dut (
      .clk(clk), .rst(rst),
      .NOOP_WB(NOOP_WB), .ADDI_WB(ADDI_WB), .MOVI_WB(MOVI_WB),
      .LW_WB(LW_WB), .SW_WB(SW_WB), .WRE_WB(WRE_WB),
      .D_out_WB(D_out_WB), .ALU_result_WB(ALU_result_WB), .Offset_WB(Offset_WB),
      .rt_WB(rt_WB), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .retire_cnt(retire_cnt), .onehot_err(onehot_err)
   );

   wb_regfile_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .NOOP_WB(NOOP_WB), .ADDI_WB(ADDI_WB), .MOVI_WB(MOVI_WB),
      .LW_WB(LW_WB), .SW_WB(SW_WB), .WRE_WB(WRE_WB),
      .D_out_WB(D_out_WB), .ALU_result_WB(ALU_result_WB), .Offset_WB(Offset_WB),
      .rt_WB(rt_WB), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a4), .rd_data_b(rd_data_b4),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data4),
      .retire_cnt(retire_cnt4), .onehot_err(onehot_err4)
   );

   // Count one comparison and report it if the observed value is wrong
   task automatic check_output(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drive one WB-stage instruction onto the stage inputs
   task automatic apply_stimulus(input logic noop, input logic addi, input logic movi,
                                 input logic lw, input logic sw, input logic wre,
                                 input logic [2:0] rt, input logic [63:0] dout,
                                 input logic [63:0] alu, input logic [63:0] off);
      NOOP_WB = noop; ADDI_WB = addi; MOVI_WB = movi; LW_WB = lw; SW_WB = sw;
      WRE_WB = wre; rt_WB = rt; D_out_WB = dout; ALU_result_WB = alu; Offset_WB = off;
   endtask

   task automatic apply_noop();
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0);
   endtask

   initial begin
      rst = 1'b1;
      apply_noop();
      rd_addr_a = 3'd0; rd_addr_b = 3'd0; dbg_addr = 3'd0;
      #12 rst = 1'b0;

      @(negedge clk); #1;
      check_output("reset_cnt", 64'(retire_cnt), 64'd0);
      check_output("reset_err", 64'(onehot_err), 64'd0);
      check_output("reset_dbg", dbg_data, 64'd0);

      // preload r1 and r7, then assert reset mid-cycle
      @(negedge clk);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, '0, 64'h11, '0);
      exp_cnt++;
      @(negedge clk);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, '0, 64'h77, '0);
      exp_cnt++;
      @(negedge clk);
      apply_noop();
      rd_addr_a = 3'd1; rd_addr_b = 3'd7; dbg_addr = 3'd7;
      @(posedge clk); #1;
      check_output("preload_r1", rd_data_a, 64'h11);
      check_output("preload_r7", rd_data_b, 64'h77);
      check_output("preload_dbg", dbg_data, 64'h77);
      check_output("preload_cnt", 64'(retire_cnt), 64'(exp_cnt));

      @(negedge clk); #2 rst = 1'b1; #1;
      exp_cnt = 0;
      check_output("async_rst_r1", rd_data_a, 64'd0);
      check_output("async_rst_r7", rd_data_b, 64'd0);
      check_output("async_rst_dbg", dbg_data, 64'd0);
      check_output("async_rst_cnt", 64'(retire_cnt), 64'd0);
      check_output("async_rst_cnt4", 64'(retire_cnt4), 64'd0);

      // an instruction held across an edge under reset is discarded
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, '0, 64'h44, '0);
      @(negedge clk);
      apply_noop();
      rst = 1'b0;
      rd_addr_a = 3'd4;
      @(posedge clk); #1;
      check_output("rst_discard_r4", rd_data_a, 64'd0);
      check_output("rst_discard_cnt", 64'(retire_cnt), 64'd0);

      // ADDI bypass on both ports, debug port shows pre-write then written value
      @(negedge clk);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, '0, 64'h1234, '0);
      rd_addr_a = 3'd3; rd_addr_b = 3'd3; dbg_addr = 3'd3;
      #1;
      check_output("addi_bypass_a", rd_data_a, 64'h1234);
      check_output("addi_bypass_b", rd_data_b, 64'h1234);
      @(posedge clk); #1;
      exp_cnt++;
      check_output("dbg_prewrite", dbg_data, 64'd0);
      @(negedge clk);
      apply_noop();
      #1;
      check_output("addi_stored", rd_data_a, 64'h1234);
      @(posedge clk); #1;
      check_output("dbg_r3", dbg_data, 64'h1234);

      // LW then MOVI back-to-back
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 64'hDEAD_BEEF, 64'h1, 64'h2);
      exp_cnt++;
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 64'h3, 64'h4,
                     64'hFFFF_FFFF_FFFF_FFF0);
      exp_cnt++;
      @(negedge clk);
      apply_noop();
      rd_addr_a = 3'd5; rd_addr_b = 3'd6;
      #1;
      check_output("lw_r5", rd_data_a, 64'hDEAD_BEEF);
      check_output("movi_r6", rd_data_b, 64'hFFFF_FFFF_FFFF_FFF0);
      check_output("lw_movi_cnt", 64'(retire_cnt), 64'(exp_cnt));

      // ADDI to r0: no write, no bypass, still retires
      @(negedge clk);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, '0, 64'h55, '0);
      rd_addr_a = 3'd0;
      #1;
      check_output("r0_no_bypass", rd_data_a, 64'd0);
      exp_cnt++;
      @(negedge clk);
      apply_noop();
      #1;
      check_output("r0_stays_zero", rd_data_a, 64'd0);
      check_output("r0_cnt", 64'(retire_cnt), 64'(exp_cnt));

      // NOOP with LW+ADDI asserted: no write, no count, no error
      @(negedge clk);
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 64'h2222, 64'h3333, '0);
      rd_addr_a = 3'd2;
      #1;
      check_output("noop_no_bypass", rd_data_a, 64'd0);
      @(negedge clk);
      apply_noop();
      #1;
      check_output("noop_r2", rd_data_a, 64'd0);
      check_output("noop_cnt", 64'(retire_cnt), 64'(exp_cnt));
      check_output("noop_err", 64'(onehot_err), 64'd0);

      // LW with WRE=0: no write but retires
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 64'h6666, '0, '0);
      #1;
      check_output("wre0_no_bypass", rd_data_a, 64'd0);
      exp_cnt++;
      @(negedge clk);
      apply_noop();
      #1;
      check_output("wre0_r2", rd_data_a, 64'd0);
      check_output("wre0_cnt", 64'(retire_cnt), 64'(exp_cnt));

      // SW never writes, retires, and alone is not an error
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 64'h7, 64'h8, 64'hAB);
      #1;
      check_output("sw_no_bypass", rd_data_a, 64'd0);
      exp_cnt++;
      @(negedge clk);
      apply_noop();
      #1;
      check_output("sw_r2", rd_data_a, 64'd0);
      check_output("sw_cnt", 64'(retire_cnt), 64'(exp_cnt));
      check_output("sw_err", 64'(onehot_err), 64'd0);

      // LW+ADDI: memory data wins, error flag set
      @(negedge clk);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 64'h4444, 64'h5555, 64'h9);
      rd_addr_a = 3'd4;
      #1;
      check_output("lw_addi_bypass", rd_data_a, 64'h4444);
      exp_cnt++;
      @(negedge clk);
      apply_noop();
      #1;
      check_output("lw_addi_r4", rd_data_a, 64'h4444);
      check_output("lw_addi_err", 64'(onehot_err), 64'd1);
      check_output("lw_addi_cnt", 64'(retire_cnt), 64'(exp_cnt));

      // SW+MOVI: SW blocks the write
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, '0, '0, 64'hCD);
      rd_addr_a = 3'd2;
      #1;
      check_output("sw_movi_no_bypass", rd_data_a, 64'd0);
      exp_cnt++;
      @(negedge clk);
      apply_noop();
      repeat (3) @(negedge clk);
      #1;
      check_output("sw_movi_r2", rd_data_a, 64'd0);
      check_output("err_sticky", 64'(onehot_err), 64'd1);
      check_output("idle_cnt", 64'(retire_cnt), 64'(exp_cnt));

      // counter wrap on the 4-bit build
      while (exp_cnt < 15) begin
         @(negedge clk);
         apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, '0, '0, 64'h1);
         exp_cnt++;
      end
      @(negedge clk);
      apply_noop();
      #1;
      check_output("cnt4_full", 64'(retire_cnt4), 64'd15);
      check_output("cnt_15", 64'(retire_cnt), 64'd15);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, '0, 64'h99, '0);
      rd_addr_a = 3'd1;
      exp_cnt++;
      @(negedge clk);
      apply_noop();
      #1;
      check_output("cnt4_wrap", 64'(retire_cnt4), 64'd0);
      check_output("cnt_16", 64'(retire_cnt), 64'd16);
      check_output("wrap_r1", rd_data_a, 64'h99);
      repeat (2) @(negedge clk);
      #1;
      check_output("cnt4_noop_hold", 64'(retire_cnt4), 64'd0);

      // reset clears the sticky error
      @(negedge clk); #2 rst = 1'b1; #1;
      check_output("rst_err", 64'(onehot_err), 64'd0);
      check_output("rst_cnt_final", 64'(retire_cnt), 64'd0);
      check_output("rst_r1_final", rd_data_a, 64'd0);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
